qspi_psram_dev: RTL and testbench

- Synthesizable QSPI PSRAM device model: the memory-side responder on the qspi_sck/qspi_ce_n/qspi_dio pins driven by the PSRAM APB bridge's QSPI controller.
- Lets the SoC run the real controller path end-to-end in simulation or on FPGA.
- Oversamples the QSPI pins with the system clock. Decodes quad read (0xEB) and quad write (0x38), and holds the bytes in an internal array.

---
 rtl/psram_pkg.sv | 22 ++
 rtl/qspi_pin_sync.sv | 59 +++++
 rtl/qspi_psram_dev.sv | 244 ++++++++++++++++++++++++
 tb/tb_qspi_psram_dev.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/psram_pkg.sv
// Shared definitions for the QSPI PSRAM device model: opcodes, protocol
// state encoding and the width of the address sent on the wire.
package psram_pkg;

   localparam int ADDR_BITS = 24;

   localparam logic [7:0] CMD_QREAD     = 8'hEB;
   localparam logic [7:0] CMD_QWRITE    = 8'h38;
   localparam logic [7:0] CMD_QPI_ENTER = 8'h35;
   localparam logic [7:0] CMD_QPI_EXIT  = 8'hF5;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      WAIT,
      RDATA,
      WDATA,
      IGNORE
   } psram_state_e;

endpackage

// File: rtl/qspi_pin_sync.sv
// Brings the asynchronous QSPI pins into the system clock domain and turns
// the synchronized sck / ce_n levels into single-clock edge pulses.
// The ce_n chain resets to 0 so that a ce_n already low when reset is
// released never looks like a falling edge: a transaction only starts on a
// genuine high-to-low transition seen after reset.
module qspi_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       qspi_sck,
   input  logic       qspi_ce_n,
   input  logic [3:0] qspi_dio_in,
   output logic [3:0] dio_s,
   output logic       sck_rise,
   output logic       sck_fall,
   output logic       ce_rise,
   output logic       ce_fall
);

   logic [SYNC_STAGES-1:0]      sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0]      ce_sync_q, ce_sync_d;
   logic [SYNC_STAGES-1:0][3:0] dio_sync_q, dio_sync_d;
   logic                        sck_prev_q, sck_prev_d;
   logic                        ce_prev_q, ce_prev_d;

   // Shift each pin one stage further down its chain and remember the last level.
   always_comb begin
      sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], qspi_sck};
      ce_sync_d  = {ce_sync_q[SYNC_STAGES-2:0], qspi_ce_n};
      dio_sync_d = {dio_sync_q[SYNC_STAGES-2:0], qspi_dio_in};
      sck_prev_d = sck_sync_q[SYNC_STAGES-1];
      ce_prev_d  = ce_sync_q[SYNC_STAGES-1];
   end

   // Synchronizer and edge-history registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         sck_sync_q <= '0;
         ce_sync_q  <= '0;
         dio_sync_q <= '0;
         sck_prev_q <= 1'b0;
         ce_prev_q  <= 1'b0;
      end else begin
         sck_sync_q <= sck_sync_d;
         ce_sync_q  <= ce_sync_d;
         dio_sync_q <= dio_sync_d;
         sck_prev_q <= sck_prev_d;
         ce_prev_q  <= ce_prev_d;
      end
   end

   assign dio_s    = dio_sync_q[SYNC_STAGES-1];
   assign sck_rise =  sck_sync_q[SYNC_STAGES-1] & ~sck_prev_q;
   assign sck_fall = ~sck_sync_q[SYNC_STAGES-1] &  sck_prev_q;
   assign ce_rise  =  ce_sync_q[SYNC_STAGES-1]  & ~ce_prev_q;
   assign ce_fall  = ~ce_sync_q[SYNC_STAGES-1]  &  ce_prev_q;

endmodule

// File: rtl/qspi_psram_dev.sv
// QSPI PSRAM device model: memory-side responder for quad read (0xEB) and
// quad write (0x38), oversampling the QSPI pins with the system clock.
// Optional QPI command mode (0x35 enter / 0xF5 exit) is compiled in when the
// macro QSPI_PSRAM_QPI_EN is defined; otherwise those opcodes are ignored.
module qspi_psram_dev
   import psram_pkg::*;
#(
   parameter int MEM_BYTES   = 4194304,
   parameter int WAIT_CYCLES = 6,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       qspi_sck,
   input  logic       qspi_ce_n,
   inout  wire  [3:0] qspi_dio
);

   localparam int AW = $clog2(MEM_BYTES);
   localparam int CW = $clog2(WAIT_CYCLES + 9);

   logic                 sck_rise, sck_fall, ce_rise, ce_fall;
   logic [3:0]           dio_s;

   psram_state_e         state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [ADDR_BITS-5:0] shift_q, shift_d;
   logic                 is_write_q, is_write_d;
   logic [AW-1:0]        addr_q, addr_d;
   logic                 nib_q, nib_d;
   logic [3:0]           wnib_q, wnib_d;
   logic [3:0]           dout_q, dout_d;

   logic                 cmd_nibbles;
   logic                 cmd_done;
   logic [7:0]           cmd_byte;
   logic [ADDR_BITS-1:0] addr_full;

   logic                 dio_oe;
   logic                 mem_we;
   logic [7:0]           mem_wdata;
   logic [7:0]           mem_rdata;
   logic [7:0]           mem [MEM_BYTES];

`ifdef QSPI_PSRAM_QPI_EN
   logic                 qpi_q, qpi_d;
   logic                 qpi_arm_q, qpi_arm_d;
   assign cmd_nibbles = qpi_q;
`else
   assign cmd_nibbles = 1'b0;
`endif

   qspi_pin_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_pin_sync (
      .clock       (clock),
      .reset       (reset),
      .qspi_sck    (qspi_sck),
      .qspi_ce_n   (qspi_ce_n),
      .qspi_dio_in (qspi_dio),
      .dio_s       (dio_s),
      .sck_rise    (sck_rise),
      .sck_fall    (sck_fall),
      .ce_rise     (ce_rise),
      .ce_fall     (ce_fall)
   );

   assign mem_rdata = mem[addr_q];

   // Protocol state register; memory contents are deliberately left out of reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         is_write_q <= 1'b0;
         addr_q     <= '0;
         nib_q      <= 1'b0;
         wnib_q     <= '0;
         dout_q     <= '0;
`ifdef QSPI_PSRAM_QPI_EN
         qpi_q      <= 1'b0;
         qpi_arm_q  <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         is_write_q <= is_write_d;
         addr_q     <= addr_d;
         nib_q      <= nib_d;
         wnib_q     <= wnib_d;
         dout_q     <= dout_d;
`ifdef QSPI_PSRAM_QPI_EN
         qpi_q      <= qpi_d;
         qpi_arm_q  <= qpi_arm_d;
`endif
      end
   end

   // Byte-wide storage, written when the low nibble of a write byte arrives.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem[addr_q] <= mem_wdata;
      end
   end

   // Next-state logic: every step is paced by a synchronized sck edge, and a
   // ce_n rise wins over everything to abandon whatever was in flight.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      is_write_d = is_write_q;
      addr_d     = addr_q;
      nib_d      = nib_q;
      wnib_d     = wnib_q;
      dout_d     = dout_q;
      cmd_done   = 1'b0;
      cmd_byte   = 8'h00;
      addr_full  = '0;
`ifdef QSPI_PSRAM_QPI_EN
      qpi_d      = qpi_q;
      qpi_arm_d  = qpi_arm_q;
`endif
      if (ce_rise) begin
         state_d = IDLE;
         cnt_d   = '0;
         nib_d   = 1'b0;
`ifdef QSPI_PSRAM_QPI_EN
         qpi_d   = qpi_arm_q;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (ce_fall) begin
                  state_d = CMD;
                  cnt_d   = '0;
`ifdef QSPI_PSRAM_QPI_EN
                  qpi_arm_d = qpi_q;
`endif
               end
            end
            CMD: begin
               if (sck_rise) begin
                  cnt_d = cnt_q + 1'b1;
                  if (cmd_nibbles) begin
                     shift_d  = {shift_q[ADDR_BITS-9:0], dio_s};
                     cmd_byte = {shift_q[3:0], dio_s};
                     cmd_done = (cnt_q == CW'(1));
                  end else begin
                     shift_d  = {shift_q[ADDR_BITS-6:0], dio_s[0]};
                     cmd_byte = {shift_q[6:0], dio_s[0]};
                     cmd_done = (cnt_q == CW'(7));
                  end
                  if (cmd_done) begin
                     cnt_d = '0;
                     case (cmd_byte)
                        CMD_QREAD: begin
                           state_d    = ADDR;
                           is_write_d = 1'b0;
                        end
                        CMD_QWRITE: begin
                           state_d    = ADDR;
                           is_write_d = 1'b1;
                        end
`ifdef QSPI_PSRAM_QPI_EN
                        CMD_QPI_ENTER: begin
                           state_d   = IGNORE;
                           qpi_arm_d = 1'b1;
                        end
                        CMD_QPI_EXIT: begin
                           state_d   = IGNORE;
                           qpi_arm_d = 1'b0;
                        end
`endif
                        default: state_d = IGNORE;
                     endcase
                  end
               end
            end
            ADDR: begin
               if (sck_rise) begin
                  shift_d = {shift_q[ADDR_BITS-9:0], dio_s};
                  cnt_d   = cnt_q + 1'b1;
                  if (cnt_q == CW'(5)) begin
                     addr_full = {shift_q, dio_s};
                     addr_d    = AW'(addr_full);
                     cnt_d     = '0;
                     nib_d     = 1'b0;
                     state_d   = is_write_q ? WDATA : WAIT;
                  end
               end
            end
            WAIT: begin
               if (sck_rise && (cnt_q != CW'(WAIT_CYCLES))) begin
                  cnt_d = cnt_q + 1'b1;
               end else if (sck_fall && (cnt_q == CW'(WAIT_CYCLES))) begin
                  state_d = RDATA;
                  dout_d  = mem_rdata[7:4];
                  nib_d   = 1'b1;
               end
            end
            RDATA: begin
               if (sck_fall) begin
                  if (nib_q) begin
                     dout_d = mem_rdata[3:0];
                     nib_d  = 1'b0;
                     addr_d = addr_q + 1'b1;
                  end else begin
                     dout_d = mem_rdata[7:4];
                     nib_d  = 1'b1;
                  end
               end
            end
            WDATA: begin
               if (sck_rise) begin
                  if (nib_q) begin
                     nib_d  = 1'b0;
                     addr_d = addr_q + 1'b1;
                  end else begin
                     wnib_d = dio_s;
                     nib_d  = 1'b1;
                  end
               end
            end
            IGNORE: begin
               state_d = IGNORE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Pin drive and memory write strobe; reset releases the bus and blocks writes at once.
   always_comb begin
      dio_oe    = (state_q == RDATA) && !reset;
      mem_we    = (state_q == WDATA) && sck_rise && nib_q && !ce_rise && !reset;
      mem_wdata = {wnib_q, dio_s};
   end

   assign qspi_dio = dio_oe ? dout_q : 4'bzzzz;

endmodule

// File: tb/tb_qspi_psram_dev.sv
// Self-checking bench for qspi_psram_dev acting as a QSPI controller.
// Builds with or without QSPI_PSRAM_QPI_EN and checks the matching behaviour.
// Expected read nibbles come from a byte-addressed reference memory and are
// queued when a read is issued; a monitor on the controller sample edge pops
// and compares them whenever the device is expected to present data.
module tb_qspi_psram_dev;

   localparam int MEM_BYTES   = 4194304;
   localparam int WAIT_CYCLES = 6;
   localparam int SYNC_STAGES = 2;
   localparam int HALF        = 60;
   localparam logic [7:0] OP_RD   = 8'hEB;
   localparam logic [7:0] OP_WR   = 8'h38;
   localparam logic [7:0] OP_QPI  = 8'h35;
   localparam logic [7:0] OP_SPI  = 8'hF5;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       qspi_sck = 1'b0;
   logic       qspi_ce_n = 1'b1;
   logic       tb_oe = 1'b0;
   logic [3:0] tb_dio = 4'h0;
   wire  [3:0] qspi_dio;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] model_mem [int];
   logic [3:0] exp_q [$];
   logic [7:0] wr_data [$];
   logic       expect_drive = 1'b0;
   logic [3:0] mon_exp;

   assign qspi_dio = tb_oe ? tb_dio : 4'bzzzz;

   always #5 clock = ~clock;

   qspi_psram_dev #(
      .MEM_BYTES   (MEM_BYTES),
      .WAIT_CYCLES (WAIT_CYCLES),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .qspi_sck  (qspi_sck),
      .qspi_ce_n (qspi_ce_n),
      .qspi_dio  (qspi_dio)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, wanted %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Controller samples on sck rise: device drive must match expectation, data must match model.
   always @(posedge qspi_sck) begin
      checkOutput("drive_enable", 32'(dut.dio_oe), 32'(expect_drive));
      if (expect_drive && exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         if (dut.dio_oe) checkOutput("read_nibble", 32'(qspi_dio), 32'(mon_exp));
      end
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic sck_cycle(input logic [3:0] d, input logic drive);
      tb_oe  = drive;
      tb_dio = d;
      #HALF;
      qspi_sck = 1'b1;
      #HALF;
      qspi_sck = 1'b0;
   endtask

   task automatic start_txn();
      qspi_ce_n = 1'b0;
      #HALF;
   endtask

   task automatic end_txn();
      tb_oe        = 1'b0;
      expect_drive = 1'b0;
      #HALF;
      qspi_ce_n = 1'b1;
      #HALF;
      checkOutput("release_after_ce", 32'(dut.dio_oe), 32'd0);
      #HALF;
   endtask

   task automatic send_cmd(input logic [7:0] op, input logic qpi);
      if (qpi) begin
         sck_cycle(op[7:4], 1'b1);
         sck_cycle(op[3:0], 1'b1);
      end else begin
         for (int i = 7; i >= 0; i--) sck_cycle({3'b000, op[i]}, 1'b1);
      end
   endtask

   task automatic send_addr(input logic [23:0] a);
      for (int i = 5; i >= 0; i--) sck_cycle(a[i*4 +: 4], 1'b1);
   endtask

   task automatic write_txn(input logic [23:0] addr, input logic qpi);
      start_txn();
      send_cmd(OP_WR, qpi);
      send_addr(addr);
      for (int i = 0; i < wr_data.size(); i++) begin
         sck_cycle(wr_data[i][7:4], 1'b1);
         sck_cycle(wr_data[i][3:0], 1'b1);
         model_mem[(int'(addr) + i) % MEM_BYTES] = wr_data[i];
      end
      end_txn();
   endtask

   task automatic read_txn(input logic [23:0] addr, input int nnib, input logic qpi);
      logic [7:0] b;
      start_txn();
      send_cmd(OP_RD, qpi);
      send_addr(addr);
      for (int i = 0; i < WAIT_CYCLES; i++) sck_cycle(4'h0, 1'b0);
      for (int n = 0; n < nnib; n++) begin
         b = model_mem[(int'(addr) + n / 2) % MEM_BYTES];
         exp_q.push_back((n % 2 == 0) ? b[7:4] : b[3:0]);
      end
      expect_drive = 1'b1;
      for (int n = 0; n < nnib; n++) sck_cycle(4'h0, 1'b0);
      end_txn();
   endtask

   // Write uses wr_data; read count is in nibbles.
   task automatic applyStimulus(input logic wr, input logic [23:0] addr, input int count, input logic qpi);
      if (wr) write_txn(addr, qpi);
      else    read_txn(addr, count, qpi);
   endtask

   initial begin
      int         base, n, off;
      logic [23:0] a;

      repeat (4) @(negedge clock);
      checkOutput("reset_oe", 32'(dut.dio_oe), 32'd0);

      // Full read issued while reset is held, then reset released mid-transaction.
      start_txn();
      send_cmd(OP_RD, 1'b0);
      send_addr(24'h000010);
      for (int i = 0; i < WAIT_CYCLES + 4; i++) sck_cycle(4'h0, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) sck_cycle(4'h0, 1'b0);
      end_txn();
      checkOutput("post_reset_oe", 32'(dut.dio_oe), 32'd0);

      // Directed write then read back.
      wr_data = '{8'hA5, 8'h3C};
      applyStimulus(1'b1, 24'h000010, 0, 1'b0);
      applyStimulus(1'b0, 24'h000010, 4, 1'b0);

      // Wrap from the last byte to address zero.
      wr_data = '{8'h11, 8'h22};
      applyStimulus(1'b1, 24'h3FFFFF, 0, 1'b0);
      applyStimulus(1'b0, 24'h3FFFFF, 4, 1'b0);
      applyStimulus(1'b0, 24'h000000, 2, 1'b0);

      // Aborted write: one nibble then ce_n high must leave the byte untouched.
      wr_data = '{8'h5A};
      applyStimulus(1'b1, 24'h000020, 0, 1'b0);
      start_txn();
      send_cmd(OP_WR, 1'b0);
      send_addr(24'h000020);
      sck_cycle(4'h7, 1'b1);
      end_txn();
      applyStimulus(1'b0, 24'h000020, 2, 1'b0);

      // Abandoned read after one nibble, then a normal read.
      applyStimulus(1'b0, 24'h000010, 1, 1'b0);
      applyStimulus(1'b0, 24'h000010, 4, 1'b0);

      // Unknown opcode followed by 40 clocks of random bus activity.
      start_txn();
      send_cmd(8'h9F, 1'b0);
      for (int i = 0; i < 40; i++) sck_cycle(4'($urandom_range(0, 15)), 1'b1);
      end_txn();
      applyStimulus(1'b0, 24'h000010, 4, 1'b0);
      applyStimulus(1'b0, 24'h000020, 2, 1'b0);

`ifdef QSPI_PSRAM_QPI_EN
      start_txn();
      send_cmd(OP_QPI, 1'b0);
      end_txn();
      applyStimulus(1'b0, 24'h000010, 2, 1'b1);
      wr_data = '{8'h6E};
      applyStimulus(1'b1, 24'h000030, 0, 1'b1);
      applyStimulus(1'b0, 24'h000030, 2, 1'b1);
      start_txn();
      send_cmd(OP_SPI, 1'b1);
      end_txn();
      applyStimulus(1'b0, 24'h000010, 4, 1'b0);
`else
      start_txn();
      send_cmd(OP_QPI, 1'b0);
      for (int i = 0; i < 4; i++) sck_cycle(4'h0, 1'b0);
      end_txn();
      applyStimulus(1'b0, 24'h000010, 4, 1'b0);
      start_txn();
      send_cmd(OP_SPI, 1'b0);
      end_txn();
      applyStimulus(1'b0, 24'h000020, 2, 1'b0);
`endif

      // Randomized bursts, some straddling the wrap point, with junk upper address bits.
      for (int r = 0; r < 8; r++) begin
         if (r % 3 == 0) base = MEM_BYTES - $urandom_range(1, 3);
         else            base = $urandom_range(0, MEM_BYTES - 1);
         a = 24'($urandom_range(0, 3) * MEM_BYTES + base);
         n = $urandom_range(1, 5);
         wr_data.delete();
         for (int i = 0; i < n; i++) wr_data.push_back(8'($urandom_range(0, 255)));
         applyStimulus(1'b1, a, 0, 1'b0);
         applyStimulus(1'b0, a, 2 * n, 1'b0);
         off = $urandom_range(0, n - 1);
         applyStimulus(1'b0, a + 24'(off), 2 * (n - off), 1'b0);
      end

      checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
